node_idx_demapper: RTL
======================

// Module: node_idx_demapper
// PURPOSE
// - Reverse of the node string->index mapper: records each (index, node string) pair at allocation,
//   then answers index lookups with the 3-letter node name as an ASCII byte stream.
// - Sits beside the mapper; fed by its allocation events, read by result/debug printers after decoding.
// - Table is writable until decoding_done, then frozen and readable through a valid/ready request port.
// PARAMETERS
// - NODE_STR_WIDTH  15                      packed node string, 3 x 5-bit letters; do not override
// - MAX_NODES       1024                    table depth
// - NODE_IDX_WIDTH  $clog2(MAX_NODES)       index width
// PORTS
// - clk            in   1                   single clock, all logic on posedge
// - rst_n          in   1                   asynchronous, active-low reset
// - assign_valid   in   1                   new index allocated this cycle
// - assign_idx     in   NODE_IDX_WIDTH      allocated index
// - assign_str     in   NODE_STR_WIDTH      packed string: [4:0]=letter0, [9:5]=letter1, [14:10]=letter2 (value = char - 'a')
// - decoding_done  in   1                   level; freezes table
// - req_valid      in   1                   lookup request
// - req_ready      out  1                   request accepted when valid&ready
// - req_idx        in   NODE_IDX_WIDTH      index to look up
// - out_valid      out  1                   ASCII byte available
// - out_ready      in   1                   consumer accepts byte
// - out_byte       out  8                   ASCII character
// - out_last       out  1                   set on third byte of a response
// - out_err        out  1                   index never assigned; constant over all 3 bytes
// - node_cnt       out  NODE_IDX_WIDTH+1    highest assigned index + 1
// BEHAVIOUR
// - Reset (rst_n=0, immediate): req_ready=0, out_valid=0, out_byte=0, out_last=0, out_err=0, node_cnt=0,
//   frozen=0, assigned bitmap all 0, FSM=FILL. Name RAM (MAX_NODES x 15, sync read) is not reset.
// - Table write: assign_valid && !frozen -> ram[assign_idx]<=assign_str, bitmap[assign_idx]<=1,
//   node_cnt<=max(node_cnt, assign_idx+1). Duplicate index overwrites string. Writes while frozen ignored.
// - frozen<=1 on first cycle decoding_done=1; clears only by reset. assign_valid and decoding_done
//   in the same cycle: write is performed, freeze effective next cycle.
// - FSM FILL: req_ready=0; -> IDLE when frozen=1.
// - IDLE: req_ready=1; on req_valid: latch req_idx, issue RAM read, -> FETCH.
// - FETCH (1 cycle): capture RAM data and known=bitmap[idx] (idx>=MAX_NODES -> known=0) -> EMIT0.
// - EMIT0/EMIT1/EMIT2: out_valid=1, out_byte = letter0/1/2 + 8'h61, or 8'h3F ('?') when !known;
//   out_err=!known; out_last=1 in EMIT2 only. Advance on out_ready; EMIT2 handshake -> IDLE.
// - Latency: request accepted at cycle N -> first byte valid at N+2; one byte per cycle under out_ready=1;
//   next request accepted the cycle after EMIT2 handshake (req_ready=0 outside IDLE).
// - Backpressure: out_byte/out_last/out_err held stable while out_valid && !out_ready.
// - Letter codes 26..31 emit the raw sum (no range check); the mapper never produces them.
// - node_cnt saturates naturally: max value MAX_NODES fits NODE_IDX_WIDTH+1 bits.
// - Reset mid-response: outputs drop immediately, pending response discarded, table and freeze lost.
// TESTING
// - Reset: rst_n=0 -> req_ready=0, out_valid=0, node_cnt=0; after release with no done, req_ready stays 0.
// - Fill idx0="you"(15'h51D8), idx1="out"(15'h4E8E), done; req idx1 at N -> 'o','u','t' on N+2..N+4,
//   out_last on 't', out_err=0, node_cnt=2.
// - req idx5 (unassigned) -> '?','?','?' with out_err=1 on all three, out_last on third.
// - out_ready low 4 cycles on byte 'u' -> out_byte stays 8'h75, out_valid stays 1, then 't' follows.
// - assign idx0="aaa"(15'h0000) after freeze -> req idx0 still returns 'y','o','u'; node_cnt unchanged.
// - rst_n low during EMIT1 -> out_valid=0 same cycle; after release req idx1 blocked until new done, then '?' x3.

Source files
------------

// File: rtl/node_idx_demapper.sv
// Reverse node-name table: records (index, packed 3-letter name) pairs until decoding_done,
// then serves index lookups as a 3-byte ASCII stream over a valid/ready port.
module node_idx_demapper #(
   parameter int NODE_STR_WIDTH = 15,
   parameter int MAX_NODES      = 1024,
   parameter int NODE_IDX_WIDTH = $clog2(MAX_NODES)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      assign_valid,
   input  logic [NODE_IDX_WIDTH-1:0] assign_idx,
   input  logic [NODE_STR_WIDTH-1:0] assign_str,
   input  logic                      decoding_done,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [NODE_IDX_WIDTH-1:0] req_idx,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_byte,
   output logic                      out_last,
   output logic                      out_err,
   output logic [NODE_IDX_WIDTH:0]   node_cnt
);

   typedef enum logic [2:0] {S_FILL, S_IDLE, S_FETCH, S_EMIT0, S_EMIT1, S_EMIT2} state_t;

   state_t                    state, state_nxt;
   logic [NODE_STR_WIDTH-1:0] ram [MAX_NODES];
   logic [NODE_STR_WIDTH-1:0] rd_data, name_q;
   logic [MAX_NODES-1:0]      assigned;
   logic [NODE_IDX_WIDTH-1:0] idx_q;
   logic [NODE_IDX_WIDTH:0]   cnt_cand;
   logic                      frozen, known_q, idx_ok, wr_en, rd_en;
   logic [4:0]                letter;

   assign wr_en    = assign_valid && !frozen;
   assign rd_en    = (state == S_IDLE) && req_valid;
   assign cnt_cand = {1'b0, assign_idx} + (NODE_IDX_WIDTH+1)'(1);

   // Index width can address past the table only when MAX_NODES is not a power of two.
   generate
      if (MAX_NODES == (1 << NODE_IDX_WIDTH)) begin : g_pow2
         assign idx_ok = 1'b1;
      end else begin : g_npow2
         assign idx_ok = (int'(idx_q) < MAX_NODES);
      end
   endgenerate

   // Name RAM: no reset, synchronous read; table is frozen before any read is issued.
   always_ff @(posedge clk) begin
      if (wr_en) ram[assign_idx] <= assign_str;
      if (rd_en) rd_data <= ram[req_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         assigned <= '0;
         node_cnt <= '0;
         frozen   <= 1'b0;
         idx_q    <= '0;
         name_q   <= '0;
         known_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            assigned[assign_idx] <= 1'b1;
            if (cnt_cand > node_cnt) node_cnt <= cnt_cand;
         end
         if (decoding_done) frozen <= 1'b1;
         if (rd_en) idx_q <= req_idx;
         if (state == S_FETCH) begin
            name_q  <= rd_data;
            known_q <= idx_ok && assigned[idx_q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FILL:  if (frozen)    state_nxt = S_IDLE;
         S_IDLE:  if (req_valid) state_nxt = S_FETCH;
         S_FETCH:                state_nxt = S_EMIT0;
         S_EMIT0: if (out_ready) state_nxt = S_EMIT1;
         S_EMIT1: if (out_ready) state_nxt = S_EMIT2;
         S_EMIT2: if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_FILL;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_err   = 1'b0;
      out_byte  = 8'h00;
      letter    = 5'd0;
      case (state)
         S_IDLE:  req_ready = 1'b1;
         S_EMIT0: letter = name_q[4:0];
         S_EMIT1: letter = name_q[9:5];
         S_EMIT2: letter = name_q[14:10];
         default: ;
      endcase
      if (state == S_EMIT0 || state == S_EMIT1 || state == S_EMIT2) begin
         out_valid = 1'b1;
         out_err   = !known_q;
         out_last  = (state == S_EMIT2);
         // Codes 26..31 pass through as raw sums; the mapper never produces them.
         out_byte  = known_q ? ({3'b000, letter} + 8'h61) : 8'h3F;
      end
   end

endmodule
